// File: rtl/mux4a2_cond_l1.sv
// Four-lane to two-lane byte interleaver running on the fast clock.
// Pair A carries lanes 0 then 1; pair B carries lanes 2 then 3.
module mux4a2_cond_l1 (
  input  logic       clk_2f,
  input  logic       reset,
  input  logic       valid0,
  input  logic       valid1,
  input  logic       valid2,
  input  logic       valid3,
  input  logic [7:0] data_in0,
  input  logic [7:0] data_in1,
  input  logic [7:0] data_in2,
  input  logic [7:0] data_in3,
  output logic       validout0,
  output logic       validout1,
  output logic [7:0] dataout0,
  output logic [7:0] dataout1,
  output logic       err_order
);

  logic            phase;
  logic [3:0][7:0] hold_d;
  logic [3:0]      hold_v;

  // phase 0 edges capture a new word and emit lanes 1/3 of the previous one;
  // phase 1 edges emit lanes 0/2. Bytes with a cleared valid are zeroed.
  always_ff @(posedge clk_2f) begin
    if (reset) begin
      phase     <= 1'b0;
      hold_d    <= '0;
      hold_v    <= '0;
      validout0 <= 1'b0;
      validout1 <= 1'b0;
      dataout0  <= 8'h00;
      dataout1  <= 8'h00;
      err_order <= 1'b0;
    end else begin
      phase <= ~phase;
      if (!phase) begin
        hold_d    <= {data_in3, data_in2, data_in1, data_in0};
        hold_v    <= {valid3, valid2, valid1, valid0};
        validout0 <= hold_v[1];
        validout1 <= hold_v[3];
        dataout0  <= hold_v[1] ? hold_d[1] : 8'h00;
        dataout1  <= hold_v[3] ? hold_d[3] : 8'h00;
        if ((valid1 & ~valid0) | (valid3 & ~valid2))
          err_order <= 1'b1;
      end else begin
        validout0 <= hold_v[0];
        validout1 <= hold_v[2];
        dataout0  <= hold_v[0] ? hold_d[0] : 8'h00;
        dataout1  <= hold_v[2] ? hold_d[2] : 8'h00;
      end
    end
  end

endmodule

// File: tb/tb_mux4a2_cond_l1.sv
// Self-checking bench for mux4a2_cond_l1: directed scenarios plus random
// traffic, checked against a per-pair byte-queue reference model.
module tb_mux4a2_cond_l1;

  logic       clk_2f = 1'b0;
  logic       reset;
  logic       valid0, valid1, valid2, valid3;
  logic [7:0] data_in0, data_in1, data_in2, data_in3;
  logic       validout0, validout1;
  logic [7:0] dataout0, dataout1;
  logic       err_order;

  int checks   = 0;
  int failures = 0;

  // Reference model: each captured word queues two bytes per pair port,
  // and every fast-clock edge after reset release pops one byte per port.
  logic [8:0] q_a[$];
  logic [8:0] q_b[$];
  int         edge_n;
  logic       err_m;
  logic [8:0] exp_a, exp_b;

  mux4a2_cond_l1 dut (
    .clk_2f(clk_2f), .reset(reset),
    .valid0(valid0), .valid1(valid1), .valid2(valid2), .valid3(valid3),
    .data_in0(data_in0), .data_in1(data_in1), .data_in2(data_in2), .data_in3(data_in3),
    .validout0(validout0), .validout1(validout1),
    .dataout0(dataout0), .dataout1(dataout1),
    .err_order(err_order)
  );

  always #5 clk_2f = ~clk_2f;

  function automatic logic [8:0] lane(input logic v, input logic [7:0] d);
    return v ? {1'b1, d} : 9'h000;
  endfunction

  task automatic cmp(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic modelEdge();
    if (reset) begin
      edge_n = 0;
      q_a.delete();
      q_b.delete();
      err_m = 1'b0;
      exp_a = 9'h000;
      exp_b = 9'h000;
    end else begin
      edge_n++;
      exp_a = (q_a.size() > 0) ? q_a.pop_front() : 9'h000;
      exp_b = (q_b.size() > 0) ? q_b.pop_front() : 9'h000;
      if (edge_n % 2 == 1) begin
        q_a.push_back(lane(valid0, data_in0));
        q_a.push_back(lane(valid1, data_in1));
        q_b.push_back(lane(valid2, data_in2));
        q_b.push_back(lane(valid3, data_in3));
        if ((valid1 && !valid0) || (valid3 && !valid2))
          err_m = 1'b1;
      end
    end
  endtask

  task automatic checkOutput(input string tag);
    cmp({tag, "_pairA"}, {validout0, dataout0}, exp_a);
    cmp({tag, "_pairB"}, {validout1, dataout1}, exp_b);
    cmp({tag, "_err"},   {8'h00, err_order},    {8'h00, err_m});
  endtask

  // Drive one set of inputs across a single rising edge, then check.
  task automatic applyStimulus(input string tag, input logic r, input logic [3:0] v,
                               input logic [7:0] d0, input logic [7:0] d1,
                               input logic [7:0] d2, input logic [7:0] d3);
    reset    = r;
    {valid3, valid2, valid1, valid0} = v;
    data_in0 = d0;
    data_in1 = d1;
    data_in2 = d2;
    data_in3 = d3;
    @(posedge clk_2f);
    #1;
    modelEdge();
    checkOutput(tag);
  endtask

  task automatic idle(input string tag);
    applyStimulus(tag, 1'b0, 4'h0, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
  endtask

  initial begin
    logic [3:0] rv;
    logic [7:0] base;

    edge_n = 0;
    err_m  = 1'b0;
    exp_a  = 9'h000;
    exp_b  = 9'h000;
    reset  = 1'b1;
    {valid3, valid2, valid1, valid0} = 4'h0;
    {data_in3, data_in2, data_in1, data_in0} = '0;

    // Reset with arbitrary inputs: everything must read zero.
    for (int i = 0; i < 3; i++) begin
      applyStimulus("reset", 1'b1, 4'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      cmp("reset_zero", {validout0, validout1, dataout0[6:0]}, 9'h000);
    end

    // Single word AA/BB/CC/DD captured at E1.
    applyStimulus("single_E1", 1'b0, 4'hF, 8'hAA, 8'hBB, 8'hCC, 8'hDD);
    cmp("single_E1_zero", {validout0, dataout0}, 9'h000);
    idle("single_E2");
    cmp("single_E2_A", {validout0, dataout0}, 9'h1AA);
    cmp("single_E2_B", {validout1, dataout1}, 9'h1CC);
    idle("single_E3");
    cmp("single_E3_A", {validout0, dataout0}, 9'h1BB);
    cmp("single_E3_B", {validout1, dataout1}, 9'h1DD);
    idle("single_E4");
    cmp("single_E4_A", {validout0, dataout0}, 9'h000);
    cmp("single_E4_B", {validout1, dataout1}, 9'h000);
    idle("single_E5");

    // Streaming incrementing words, each held for two fast cycles.
    applyStimulus("stream_rst", 1'b1, 4'h0, 8'h00, 8'h00, 8'h00, 8'h00);
    for (int w = 0; w < 10; w++) begin
      base = 8'(w * 4);
      for (int h = 0; h < 2; h++)
        applyStimulus("stream", 1'b0, 4'hF, base, base + 8'd1, base + 8'd2, base + 8'd3);
      if (w >= 1)
        cmp("stream_valid", {8'h00, validout0 & validout1}, 9'h001);
    end
    idle("stream_drain");
    cmp("stream_last_A", {validout0, dataout0}, 9'h125);

    // Partial valid: lane1 invalid but carrying 5A must not leak.
    applyStimulus("partial_rst", 1'b1, 4'h0, 8'h00, 8'h00, 8'h00, 8'h00);
    applyStimulus("partial_E1", 1'b0, 4'h1, 8'h3C, 8'h5A, 8'h77, 8'h88);
    idle("partial_E2");
    cmp("partial_E2_A", {validout0, dataout0}, 9'h13C);
    idle("partial_E3");
    cmp("partial_E3_A", {validout0, dataout0}, 9'h000);
    cmp("partial_err", {8'h00, err_order}, 9'h000);

    // Order violation latches err_order until reset.
    applyStimulus("order_rst", 1'b1, 4'h0, 8'h00, 8'h00, 8'h00, 8'h00);
    applyStimulus("order_E1", 1'b0, 4'h2, 8'h11, 8'h22, 8'h33, 8'h44);
    cmp("order_set", {8'h00, err_order}, 9'h001);
    for (int i = 0; i < 4; i++) idle("order_idle");
    cmp("order_sticky", {8'h00, err_order}, 9'h001);
    applyStimulus("order_clr", 1'b1, 4'h0, 8'h00, 8'h00, 8'h00, 8'h00);
    cmp("order_cleared", {8'h00, err_order}, 9'h000);

    // Mid-stream reset drops pending lane1/lane3 bytes.
    applyStimulus("mid_E1", 1'b0, 4'hF, 8'h61, 8'h62, 8'h63, 8'h64);
    idle("mid_E2");
    applyStimulus("mid_rst", 1'b1, 4'hF, 8'h71, 8'h72, 8'h73, 8'h74);
    cmp("mid_rst_A", {validout0, dataout0}, 9'h000);
    applyStimulus("mid_E1b", 1'b0, 4'hF, 8'h81, 8'h82, 8'h83, 8'h84);
    cmp("mid_E1b_A", {validout0, dataout0}, 9'h000);
    idle("mid_E2b");
    cmp("mid_E2b_A", {validout0, dataout0}, 9'h181);
    idle("mid_E3b");
    cmp("mid_E3b_B", {validout1, dataout1}, 9'h184);

    // Random traffic with occasional resets; mostly legal valid patterns.
    for (int i = 0; i < 400; i++) begin
      rv = 4'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        if (rv[1]) rv[0] = 1'b1;
        if (rv[3]) rv[2] = 1'b1;
      end
      applyStimulus("random", ($urandom_range(0, 49) == 0), rv,
                    8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
